// File: rtl/gamma_loader.sv
// rtl/gamma_loader.sv - gamma table loader: host-stream or identity-ramp fill of a 1024x8 correction table
module gamma_loader #(
  parameter int NUM_ENTRIES = 768,
  parameter int TIMEOUT     = 4095
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       load_start,
  input  logic       linear_start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       en_req,
  input  logic       gamma_present,
  output logic       gamma_en,
  output logic       gamma_wr,
  output logic [9:0] gamma_wr_addr,
  output logic [7:0] gamma_value,
  output logic       busy,
  output logic       loaded,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          src_gen_q, src_gen_d;
  logic [9:0]    addr_q, addr_d;
  logic [1:0]    comp_q, comp_d;
  logic [7:0]    level_q, level_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    val_q, val_d;
  logic [9:0]    wa_q, wa_d;
  logic          loaded_q, loaded_d;
  logic          error_q, error_d;
  logic          gamma_en_q, gamma_en_d;
  logic          start;

  assign start = gamma_present & (load_start | linear_start);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_gen_q  <= 1'b0;
      addr_q     <= '0;
      comp_q     <= '0;
      level_q    <= '0;
      tmo_q      <= '0;
      val_q      <= '0;
      wa_q       <= '0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      gamma_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_gen_q  <= src_gen_d;
      addr_q     <= addr_d;
      comp_q     <= comp_d;
      level_q    <= level_d;
      tmo_q      <= tmo_d;
      val_q      <= val_d;
      wa_q       <= wa_d;
      loaded_q   <= loaded_d;
      error_q    <= error_d;
      gamma_en_q <= gamma_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_gen_d = src_gen_q;
    addr_d    = addr_q;
    comp_d    = comp_q;
    level_d   = level_q;
    tmo_d     = tmo_q;
    val_d     = val_q;
    wa_d      = wa_q;
    loaded_d  = loaded_q;
    error_d   = error_q;
    // Losing the correction stage outranks a restart request.
    if (state_q != S_IDLE && !gamma_present) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end else if (start) begin
      state_d   = load_start ? S_LOAD : S_GEN;
      src_gen_d = ~load_start;
      addr_d    = '0;
      comp_d    = '0;
      level_d   = '0;
      tmo_d     = '0;
      error_d   = 1'b0;
      loaded_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (din_valid) begin
            val_d   = din;
            wa_d    = addr_q;
            tmo_d   = '0;
            state_d = S_WRITE;
          end else if (tmo_q + TW'(1) == TW'(TIMEOUT)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_GEN: begin
          val_d   = level_q;
          wa_d    = addr_q;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (addr_q == 10'(NUM_ENTRIES - 1)) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 10'd1;
            state_d = src_gen_q ? S_GEN : S_LOAD;
            if (comp_q == 2'd2) begin
              comp_d  = 2'd0;
              level_d = level_q + 8'd1;
            end else begin
              comp_d = comp_q + 2'd1;
            end
          end
        end
        S_DONE: begin
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    din_ready  = (state_q == S_LOAD);
    gamma_wr   = (state_q == S_WRITE);
    busy       = (state_q != S_IDLE);
    // A start pulse must not let a stale enable leak into the first load cycle.
    gamma_en_d = en_req & loaded_q & gamma_present & (state_q == S_IDLE) & ~start;
  end

  assign gamma_en      = gamma_en_q;
  assign gamma_wr_addr = wa_q;
  assign gamma_value   = val_q;
  assign loaded        = loaded_q;
  assign error         = error_q;

endmodule

// File: doc/gamma_loader.md
GAMMA_LOADER -- requirements
Module: gamma_loader

Interface
REQ-001 Parameter: NUM_ENTRIES, 768, table words written per load (256 levels x 3 components); legal range 1..1024.
REQ-002 Parameter: TIMEOUT, 4095, idle clk_sys cycles tolerated between stream bytes during LOAD before abort.
REQ-003 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 load_start  in  1  one-cycle pulse; begin host-stream load.
REQ-006 linear_start  in  1  one-cycle pulse; begin internally generated identity ramp.
REQ-007 din  in  8  host stream byte.
REQ-008 din_valid  in  1  din is valid.
REQ-009 din_ready  out  1  loader accepts din this cycle.
REQ-010 en_req  in  1  user setting: gamma wanted.
REQ-011 gamma_present  in  1  correction stage exists (gamma_bus[21]).
REQ-012 gamma_en  out  1  drives gamma_bus[19].
REQ-013 gamma_wr  out  1  drives gamma_bus[18]; one-cycle write strobe.
REQ-014 gamma_wr_addr  out  10  drives gamma_bus[17:8].
REQ-015 gamma_value  out  8  drives gamma_bus[7:0].
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 loaded  out  1  a complete table has been written since reset.
REQ-018 error  out  1  sticky; last load aborted (timeout or restart); cleared by next start pulse.

Function
REQ-019 States SHALL be IDLE, LOAD, GEN, WRITE, DONE; gamma_bus[20] is driven with clk_sys by the parent, not this block.
REQ-020 IDLE: load_start -> LOAD, linear_start -> GEN; both same cycle -> LOAD wins; either ignored when gamma_present=0.
REQ-021 On any start: addr counter <= 0, timeout counter <= 0, error <= 0, loaded <= 0.
REQ-022 gamma_en SHALL equal en_req & loaded & gamma_present & (state==IDLE), registered (one cycle latency); forced 0 throughout any load.
REQ-023 LOAD: din_ready=1; on din_valid&din_ready latch din into gamma_value, gamma_wr_addr<=addr, go WRITE.
REQ-024 WRITE: gamma_wr=1 for exactly one cycle, din_ready=0; addr increments; if addr was NUM_ENTRIES-1 -> DONE else return to LOAD/GEN by source.
REQ-025 Max throughput one table word per 2 cycles; gamma_value/gamma_wr_addr stable while gamma_wr=1.
REQ-026 GEN: no stream consumed (din_ready=0); gamma_value = addr/3 truncated to 8 bits (identity ramp, each level repeated for R,G,B); go WRITE next cycle.
REQ-027 addr/3 SHALL be realised by a component counter (0..2) and level counter (0..255) advancing with addr, not a divider.
REQ-028 Timeout counter counts LOAD cycles without a handshake, clears on handshake; reaching TIMEOUT -> error<=1, IDLE, loaded stays 0.
REQ-029 load_start or linear_start while busy: abort current load, error<=1 for one cycle only if then cleared by restart rule (net: error=0), restart from addr 0 in the requested mode.
REQ-030 DONE: loaded<=1 for the completed table, next cycle IDLE; din bytes beyond NUM_ENTRIES are not accepted (din_ready=0 outside LOAD).
REQ-031 addr SHALL never exceed NUM_ENTRIES-1; no wrap within a load.
REQ-032 gamma_present falling while busy: abort to IDLE, error<=1.

Reset
REQ-033 reset_n low asynchronously forces: state IDLE, din_ready 0, gamma_wr 0, gamma_wr_addr 0, gamma_value 0, gamma_en 0, busy 0, loaded 0, error 0, counters 0.
REQ-034 Outputs leave reset values no earlier than the first clk_sys edge after reset_n rises.

Verification
REQ-035 linear_start, NUM_ENTRIES=768 -> 768 gamma_wr pulses, addr 0..767 in order, value at addr 5 = 1, addr 767 = 255, loaded=1, gamma_en=1 with en_req=1.
REQ-036 load_start, stream 768 bytes back-to-back din_valid=1 -> one write per 2 cycles, value[n]=din[n], 1536 cycles LOAD/WRITE, then loaded=1.
REQ-037 load_start, stop stream after 100 bytes, TIMEOUT=16 -> error=1 after 16 idle cycles, busy=0, loaded=0, gamma_en=0.
REQ-038 load_start mid-GEN at addr 300 -> next write addr 0 from din, error=0, gamma_en stays 0 until new table done.
REQ-039 reset_n pulsed low mid-LOAD (asynchronous, between edges) -> all outputs at reset values immediately; gamma_present=0 then load_start -> busy stays 0.
